// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern generator and its timing core.
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PAT_GRID    = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_SOLID   = 2'd3
    } pattern_e;

    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    // Total line or frame length from porch, pulse and display widths.
    function automatic int unsigned total_len(input int unsigned fp, input int unsigned pulse,
                                              input int unsigned bp, input int unsigned disp);
        return fp + pulse + bp + disp;
    endfunction

    // Colour of bar idx, left to right.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_if.sv
// Video output bundle: syncs, blank and pixel colour.
interface video_if;
    import video_pkg::*;

    logic HS;
    logic VS;
    logic BLANK;
    rgb_t RGB;

    modport master (output HS, VS, BLANK, RGB);
    modport slave  (input  HS, VS, BLANK, RGB);

endinterface

// File: rtl/video_timing.sv
// Horizontal/vertical counters with sync, active-area and coordinate decode.
module video_timing import video_pkg::*; #(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned HFP    = 40,
    parameter int unsigned HPULSE = 48,
    parameter int unsigned HBP    = 40,
    parameter int unsigned VFP    = 13,
    parameter int unsigned VPULSE = 3,
    parameter int unsigned VBP    = 29,
    localparam int unsigned HTOTAL = total_len(HFP, HPULSE, HBP, HDISP),
    localparam int unsigned VTOTAL = total_len(VFP, VPULSE, VBP, VDISP),
    localparam int unsigned HW     = $clog2(HTOTAL),
    localparam int unsigned VW     = $clog2(VTOTAL),
    localparam int unsigned XW     = $clog2(HDISP),
    localparam int unsigned YW     = $clog2(VDISP)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    output logic [HW-1:0] h,
    output logic          hs,
    output logic          vs,
    output logic          active,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start
);

    localparam logic [HW-1:0] HMAX     = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] HSYNC_B  = HW'(HFP);
    localparam logic [HW-1:0] HSYNC_E  = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] HSTART_C = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] VMAX     = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] VSYNC_B  = VW'(VFP);
    localparam logic [VW-1:0] VSYNC_E  = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] VSTART_C = VW'(VFP + VPULSE + VBP);

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;
    logic [HW-1:0] h_off;
    logic [VW-1:0] v_off;

    // Raster counters; v advances on the h wrap, both wrap together at frame end.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HMAX) begin
            h_q <= '0;
            v_q <= (v_q == VMAX) ? '0 : v_q + 1'b1;
        end else begin
            h_q <= h_q + 1'b1;
        end
    end

    // Stage-0 decode of the current counter position.
    always_comb begin
        h_off       = h_q - HSTART_C;
        v_off       = v_q - VSTART_C;
        hs          = !((h_q >= HSYNC_B) && (h_q < HSYNC_E));
        vs          = !((v_q >= VSYNC_B) && (v_q < VSYNC_E));
        active      = (h_q >= HSTART_C) && (v_q >= VSTART_C);
        x           = active ? XW'(h_off) : '0;
        y           = active ? YW'(v_off) : '0;
        frame_start = (h_q == '0) && (v_q == '0);
    end

    assign h = h_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Test pattern generator: timing core, frame-synchronous mode latch, pattern
// select and a matched output pipeline.
module video_pattern_gen import video_pkg::*; #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter int unsigned HFP       = 40,
    parameter int unsigned HPULSE    = 48,
    parameter int unsigned HBP       = 40,
    parameter int unsigned VFP       = 13,
    parameter int unsigned VPULSE    = 3,
    parameter int unsigned VBP       = 29,
    parameter int unsigned GRID_LOG2 = 4,
    parameter int unsigned PIPE      = 2,
    parameter int unsigned FCNT_W    = 16,
    localparam int unsigned XW       = $clog2(HDISP),
    localparam int unsigned YW       = $clog2(VDISP)
) (
    input  logic              pixel_clk,
    input  logic              pixel_rst,
    input  logic [1:0]        mode_i,
    input  logic [23:0]       color_i,
    video_if.master           vid,
    output logic [XW-1:0]     x_o,
    output logic [YW-1:0]     y_o,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned HTOTAL = total_len(HFP, HPULSE, HBP, HDISP);
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned HSTART = HFP + HPULSE + HBP;
    localparam int unsigned BAR_W  = HDISP / 8;
    localparam int unsigned PXW    = $clog2(HDISP + 1);

    localparam logic [HW-1:0]  HSTART_C = HW'(HSTART);
    // Bar state clears one pixel before the active area of every line.
    localparam logic [HW-1:0]  HCLR_C   = HW'((HSTART == 0) ? HTOTAL - 1 : HSTART - 1);
    localparam logic [PXW-1:0] BAR_LAST = PXW'(BAR_W - 1);

    typedef struct packed {
        logic              hs;
        logic              vs;
        logic              blank;
        rgb_t              rgb;
        logic [XW-1:0]     x;
        logic [YW-1:0]     y;
        logic              fs;
        logic [FCNT_W-1:0] fcnt;
    } pipe_t;

    localparam pipe_t PIPE_RST = '{hs: 1'b1, vs: 1'b1, default: '0};

    logic [HW-1:0]     t_h;
    logic              t_hs;
    logic              t_vs;
    logic              t_active;
    logic [XW-1:0]     t_x;
    logic [YW-1:0]     t_y;
    logic              t_fs;

    pattern_e          mode_q;
    rgb_t              color_q;
    logic [PXW-1:0]    bar_px_q;
    logic [2:0]        bar_idx_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_s0;
    pipe_t             s0;
    pipe_t             pipe_q [PIPE];

    video_timing #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP)
    ) u_timing (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .h           (t_h),
        .hs          (t_hs),
        .vs          (t_vs),
        .active      (t_active),
        .x           (t_x),
        .y           (t_y),
        .frame_start (t_fs)
    );

    // Pattern request and solid colour only change at frame start.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            mode_q  <= PAT_GRID;
            color_q <= '0;
        end else if (t_fs) begin
            mode_q  <= pattern_e'(mode_i);
            color_q <= color_i;
        end
    end

    // Divider-free bar tracking; the last bar keeps any leftover pixels.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst || (t_h == HCLR_C)) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else if (t_h >= HSTART_C) begin
            if ((bar_px_q == BAR_LAST) && (bar_idx_q != 3'd7)) begin
                bar_px_q  <= '0;
                bar_idx_q <= bar_idx_q + 3'd1;
            end else begin
                bar_px_q  <= bar_px_q + 1'b1;
            end
        end
    end

    // Frame counter; the incremented value travels with its frame_start.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_s0;
        end
    end

    // Stage-0 output word: decoded timing plus the selected pattern colour.
    always_comb begin
        fcnt_s0  = t_fs ? fcnt_q + 1'b1 : fcnt_q;
        s0       = '0;
        s0.hs    = t_hs;
        s0.vs    = t_vs;
        s0.blank = t_active;
        s0.x     = t_x;
        s0.y     = t_y;
        s0.fs    = t_fs;
        s0.fcnt  = fcnt_s0;
        if (t_active) begin
            unique case (mode_q)
                PAT_GRID: s0.rgb = ((t_x[GRID_LOG2-1:0] == '0) || (t_y[GRID_LOG2-1:0] == '0))
                                   ? RGB_WHITE : RGB_BLACK;
                PAT_BARS:    s0.rgb = bar_color(bar_idx_q);
                PAT_CHECKER: s0.rgb = (t_x[GRID_LOG2] ^ t_y[GRID_LOG2]) ? RGB_WHITE : RGB_BLACK;
                PAT_SOLID:   s0.rgb = color_q;
            endcase
        end
    end

    // Matched output pipeline keeps every output on the same latency.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else begin
            pipe_q[0] <= s0;
            for (int i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign vid.HS      = pipe_q[PIPE-1].hs;
    assign vid.VS      = pipe_q[PIPE-1].vs;
    assign vid.BLANK   = pipe_q[PIPE-1].blank;
    assign vid.RGB     = pipe_q[PIPE-1].rgb;
    assign x_o         = pipe_q[PIPE-1].x;
    assign y_o         = pipe_q[PIPE-1].y;
    assign frame_start = pipe_q[PIPE-1].fs;
    assign frame_cnt   = pipe_q[PIPE-1].fcnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a small raster (38 x 11 total, 32 x 8 active).
module tb_video_pattern_gen;

    localparam int HDISP = 32, VDISP = 8, HFP = 2, HPULSE = 3, HBP = 1;
    localparam int VFP = 1, VPULSE = 1, VBP = 1, GRID_LOG2 = 2, PIPE = 2, FCNT_W = 2;
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HSTART = HFP + HPULSE + HBP;
    localparam int VSTART = VFP + VPULSE + VBP;
    localparam int G = 1 << GRID_LOG2;
    localparam int BAR_W = HDISP / 8;
    localparam int FRAME = HTOTAL * VTOTAL;
    // Output word with HS=1, VS=1 and everything else zero.
    localparam logic [63:0] RST_VEC = (64'd1 << 37) | (64'd1 << 36);

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic [1:0]  mode_i;
    logic [23:0] color_i;
    logic [4:0]  x_o;
    logic [2:0]  y_o;
    logic        frame_start;
    logic [1:0]  frame_cnt;

    video_if vif ();

    video_pattern_gen #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .GRID_LOG2(GRID_LOG2),
        .PIPE(PIPE), .FCNT_W(FCNT_W)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .mode_i      (mode_i),
        .color_i     (color_i),
        .vid         (vif),
        .x_o         (x_o),
        .y_o         (y_o),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, last_fs = 0, blank_cnt = 0, spot_mode = 0;
    int mh = 0, mv = 0, mfc = 0;
    logic [1:0]  mmode = 2'd0;
    logic [23:0] mcol = 24'd0;
    logic [63:0] expq[$];
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic hs, input logic vs, input logic blank,
                                         input logic [23:0] rgb, input logic [4:0] x,
                                         input logic [2:0] y, input logic fs,
                                         input logic [1:0] fc);
        return {26'd0, hs, vs, blank, rgb, x, y, fs, fc};
    endfunction

    function automatic logic [63:0] dut_word();
        return pack(vif.HS, vif.VS, vif.BLANK, vif.RGB, x_o, y_o, frame_start, frame_cnt);
    endfunction

    // Pattern colour of an active pixel from the pattern definitions.
    function automatic logic [23:0] model_rgb(input int x, input int y, input logic [1:0] m,
                                              input logic [23:0] c);
        int b;
        case (m)
            2'd0: return ((x % G == 0) || (y % G == 0)) ? 24'hFFFFFF : 24'h000000;
            2'd1: begin
                b = x / BAR_W;
                if (b > 7) b = 7;
                return bars[b];
            end
            2'd2: return (((x / G) + (y / G)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            default: return c;
        endcase
    endfunction

    // One clock: advance the reference raster, then compare the DUT output word.
    task automatic tick();
        logic hs, vs, act, fs;
        int x, y;
        @(posedge pixel_clk);
        cyc++;
        if (pixel_rst) begin
            mh = 0; mv = 0; mfc = 0; mmode = 2'd0; mcol = 24'd0;
            expq.delete();
            repeat (PIPE) expq.push_back(RST_VEC);
        end else begin
            fs = (mh == 0) && (mv == 0);
            if (fs) begin
                mmode = mode_i;
                mcol  = color_i;
                mfc   = (mfc + 1) % (1 << FCNT_W);
            end
            hs  = !(mh >= HFP && mh < HFP + HPULSE);
            vs  = !(mv >= VFP && mv < VFP + VPULSE);
            act = (mh >= HSTART) && (mv >= VSTART);
            x   = act ? mh - HSTART : 0;
            y   = act ? mv - VSTART : 0;
            expq.push_back(pack(hs, vs, act, act ? model_rgb(x, y, mmode, mcol) : 24'd0,
                                x[4:0], y[2:0], fs, mfc[1:0]));
            void'(expq.pop_front());
            mh++;
            if (mh == HTOTAL) begin
                mh = 0;
                mv++;
                if (mv == VTOTAL) mv = 0;
            end
        end
        #1;
        chk("pixel", dut_word(), expq[0]);
        if (vif.BLANK) blank_cnt++;
        if (vif.BLANK && spot_mode == 0) begin
            if (y_o == 0 || y_o == 4) chk("grid_hline", 64'(vif.RGB), 64'h00FFFFFF);
            else if (y_o == 1 && x_o <= 8)
                chk("grid_row1", 64'(vif.RGB), (x_o % 4 == 0) ? 64'h00FFFFFF : 64'h0);
        end
        if (vif.BLANK && spot_mode == 1 && y_o == 2) begin
            if (x_o < 4) chk("bar_white", 64'(vif.RGB), 64'h00FFFFFF);
            else if (x_o < 8) chk("bar_yellow", 64'(vif.RGB), 64'h00FFFF00);
            else if (x_o >= 28) chk("bar_black", 64'(vif.RGB), 64'h0);
        end
        if (vif.BLANK && spot_mode == 3) chk("solid", 64'(vif.RGB), 64'h00123456);
    endtask

    task automatic wait_fs(input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!frame_start && k < budget);
        chk("wait_fs", 64'(frame_start), 64'd1);
    endtask

    initial begin
        pixel_rst = 1'b1;
        mode_i    = 2'd0;
        color_i   = 24'd0;
        repeat (5) tick();
        chk("reset_vec", dut_word(), RST_VEC);

        // First frame_start two cycles after release, HS low for 3 cycles from cycle 4.
        pixel_rst = 1'b0;
        tick(); chk("fs_not_yet", 64'(frame_start), 64'd0);
        tick(); chk("fs_first", 64'(frame_start), 64'd1);
        chk("fcnt_first", 64'(frame_cnt), 64'd1);
        last_fs   = cyc;
        blank_cnt = 0;
        tick(); chk("hs_pre", 64'(vif.HS), 64'd1);
        repeat (3) begin
            tick(); chk("hs_low", 64'(vif.HS), 64'd0);
        end
        tick(); chk("hs_end", 64'(vif.HS), 64'd1);

        // Frame period, frame counter including its wrap, active pixel count.
        for (int f = 2; f <= 5; f++) begin
            wait_fs(FRAME + 10);
            chk("fs_period", 64'(cyc - last_fs), 64'(FRAME));
            chk("fcnt", 64'(frame_cnt), 64'(f % 4));
            last_fs = cyc;
            if (f == 4) chk("blank_3frames", 64'(blank_cnt), 64'(3 * HDISP * VDISP));
        end

        // Colour bars for one frame, then back to grid.
        mode_i = 2'd1;
        wait_fs(FRAME + 10);
        spot_mode = 1;
        mode_i = 2'd0;
        wait_fs(FRAME + 10);
        spot_mode = 0;

        // Mid-frame switch to solid: rest of this frame stays grid.
        repeat (200) tick();
        mode_i  = 2'd3;
        color_i = 24'h123456;
        wait_fs(FRAME + 10);
        spot_mode = 3;

        // Reset in the middle of the frame at v=5.
        begin
            int k = 0;
            while (mv != 5 && k < FRAME) begin
                tick();
                k++;
            end
            chk("reach_v5", 64'(mv), 64'd5);
        end
        pixel_rst = 1'b1;
        tick(); chk("mid_reset", dut_word(), RST_VEC);
        spot_mode = -1;
        pixel_rst = 1'b0;
        tick(); chk("fs_rst_not_yet", 64'(frame_start), 64'd0);
        tick(); chk("fs_after_rst", 64'(frame_start), 64'd1);
        chk("fcnt_after_rst", 64'(frame_cnt), 64'd1);

        // Random mode/colour changes and occasional reset pulses.
        for (int i = 0; i < 5 * FRAME; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mode_i  = 2'($urandom_range(0, 3));
                color_i = 24'($urandom);
            end
            pixel_rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        pixel_rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
